quad_decoder_multi: RTL and testbench

//  Parametrised N-channel quadrature decoder (A/B) replacing the single-channel slot counter.

---
 rtl/quad_decoder_multi_pkg.sv | 65 ++++++
 rtl/quad_decoder_multi_if.sv | 40 ++++
 rtl/quad_decoder_multi_chan.sv | 158 +++++++++++++++
 rtl/quad_decoder_multi.sv | 76 +++++++
 tb/tb_quad_decoder_multi.sv | 365 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/quad_decoder_multi_pkg.sv
// ---------------------------------------------------------------------------
// quad_decoder_multi_pkg
//   Shared definitions for the multi-channel quadrature decoder:
//   decode-mode encodings, forward/reverse {A,B} state-pair constants,
//   the step classification type and helper functions, default widths
//   and the SPI field offsets used by the command decoder.
// ---------------------------------------------------------------------------
package quad_decoder_multi_pkg;

  // Counts per quadrature cycle
  localparam int DECODE_X1 = 1;
  localparam int DECODE_X2 = 2;
  localparam int DECODE_X4 = 4;

  localparam int NUM_CH_DEFAULT    = 7;
  localparam int CNT_WIDTH_DEFAULT = 32;

  // Field offsets inside the C_SET_QUAD_COUNTS / C_READ_INTERUPTS payloads
  localparam int QUAD_VALUE_LSB = 0;
  localparam int QUAD_CH_LSB    = 32;
  localparam int QUAD_INTR_LSB  = 0;

  // {prev,cur} pairs of the forward sequence 00->10->11->01->00
  localparam logic [3:0] FWD_00_10 = 4'b00_10;
  localparam logic [3:0] FWD_10_11 = 4'b10_11;
  localparam logic [3:0] FWD_11_01 = 4'b11_01;
  localparam logic [3:0] FWD_01_00 = 4'b01_00;
  // Reverse sequence pairs
  localparam logic [3:0] REV_10_00 = 4'b10_00;
  localparam logic [3:0] REV_11_10 = 4'b11_10;
  localparam logic [3:0] REV_01_11 = 4'b01_11;
  localparam logic [3:0] REV_00_01 = 4'b00_01;

  typedef enum logic [1:0] {
    STEP_NONE,
    STEP_UP,
    STEP_DOWN,
    STEP_ILLEGAL
  } step_e;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

  // Both bits changing at once cannot be ordered, so it is illegal
  function automatic step_e classifyStep(input logic [1:0] prevAb,
                                         input logic [1:0] curAb);
    step_e kind;
    case ({prevAb, curAb})
      FWD_00_10, FWD_10_11, FWD_11_01, FWD_01_00: kind = STEP_UP;
      REV_10_00, REV_11_10, REV_01_11, REV_00_01: kind = STEP_DOWN;
      default: kind = (prevAb == curAb) ? STEP_NONE : STEP_ILLEGAL;
    endcase
    return kind;
  endfunction

endpackage

// File: rtl/quad_decoder_multi_if.sv
// ---------------------------------------------------------------------------
// quad_decoder_multi_if
//   Host-side bus of the decoder: count load and compare writes from the
//   SPI command decoder, the interrupt clear mask, and the status/count
//   read-back.
//   master : SPI command decoder side (drives ld/cmp/clr, reads status)
//   slave  : decoder side
// ---------------------------------------------------------------------------
interface quad_decoder_multi_if #(
  parameter int NUM_CH    = 7,
  parameter int CNT_WIDTH = 32
);
  import quad_decoder_multi_pkg::*;

  localparam int CH_W = (NUM_CH > 1) ? clog2(NUM_CH) : 1;

  logic                        ld_valid;
  logic [CH_W-1:0]             ld_ch;
  logic [CNT_WIDTH-1:0]        ld_value;
  logic                        cmp_valid;
  logic [CH_W-1:0]             cmp_ch;
  logic [CNT_WIDTH-1:0]        cmp_value;
  logic [NUM_CH-1:0]           intr_clr;
  logic [NUM_CH*CNT_WIDTH-1:0] count_flat;
  logic [NUM_CH-1:0]           dir;
  logic [NUM_CH-1:0]           err;
  logic [NUM_CH-1:0]           intr_pend;
  logic                        intrpt_out;

  modport master (
    output ld_valid, ld_ch, ld_value, cmp_valid, cmp_ch, cmp_value, intr_clr,
    input  count_flat, dir, err, intr_pend, intrpt_out
  );

  modport slave (
    input  ld_valid, ld_ch, ld_value, cmp_valid, cmp_ch, cmp_value, intr_clr,
    output count_flat, dir, err, intr_pend, intrpt_out
  );

endinterface

// File: rtl/quad_decoder_multi_chan.sv
// ---------------------------------------------------------------------------
// quad_decoder_multi_chan
//   One decoder channel: two-flop synchroniser, run-length glitch filter,
//   x1/x2/x4 decode, wrapping up/down count, compare-match flag and sticky
//   illegal-transition flag.
//   clk, resetn          : clock, async active-low reset
//   quad_a_i, quad_b_i   : raw asynchronous A/B pins
//   ld_en_i, ld_value_i  : load strobe already qualified for this channel
//   cmp_en_i, cmp_value_i: compare write already qualified for this channel
//   clr_i                : clears pend_o and err_o
//   count_o, dir_o, err_o, pend_o : registered channel state
// ---------------------------------------------------------------------------
module quad_decoder_multi_chan
  import quad_decoder_multi_pkg::*;
#(
  parameter int CNT_WIDTH   = CNT_WIDTH_DEFAULT,
  parameter int FILTER_LEN  = 4,
  parameter int DECODE_MODE = DECODE_X4
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 quad_a_i,
  input  logic                 quad_b_i,
  input  logic                 ld_en_i,
  input  logic [CNT_WIDTH-1:0] ld_value_i,
  input  logic                 cmp_en_i,
  input  logic [CNT_WIDTH-1:0] cmp_value_i,
  input  logic                 clr_i,
  output logic [CNT_WIDTH-1:0] count_o,
  output logic                 dir_o,
  output logic                 err_o,
  output logic                 pend_o
);

  localparam int RUN_W = (clog2(FILTER_LEN + 1) > 0) ? clog2(FILTER_LEN + 1) : 1;
  localparam logic [RUN_W-1:0] RUN_FULL = RUN_W'(FILTER_LEN);
  localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);

  logic [1:0]           sync1_q, sync2_q;
  logic [1:0]           syncVld_q;
  logic [1:0]           cand_q, cand_d;
  logic [RUN_W-1:0]     run_q, run_d;
  logic [1:0]           filt_q, filt_d;
  logic                 filtVld_q, filtVld_d;
  logic [1:0]           last_q;
  logic                 lastVld_q;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic [CNT_WIDTH-1:0] cmp_q, cmp_d;
  logic                 dir_q, dir_d;
  logic                 err_q, err_d;
  logic                 pend_q, pend_d;

  step_e                stepKind;
  logic                 stepEn;
  logic [CNT_WIDTH-1:0] stepVal;

  // Filter: syncVld_q marks when sync2_q holds real pin data rather than
  // its reset value, so the filter never accepts a fake 00 after reset.
  // run_q==0 means no candidate yet; the filtered level is replaced once
  // the candidate has been seen FILTER_LEN times in a row.
  always_comb begin
    cand_d    = cand_q;
    run_d     = run_q;
    filt_d    = filt_q;
    filtVld_d = filtVld_q;
    if (syncVld_q[1]) begin
      if ((sync2_q == cand_q) && (run_q != '0)) begin
        if (run_q != RUN_FULL) begin
          run_d = run_q + RUN_ONE;
        end
      end else begin
        cand_d = sync2_q;
        run_d  = RUN_ONE;
      end
      if (run_d == RUN_FULL) begin
        filt_d    = cand_d;
        filtVld_d = 1'b1;
      end
    end
  end

  // Decode compares the filtered level with its one-cycle-old copy; the
  // very first accepted level has no valid predecessor and only seeds it.
  always_comb begin
    stepKind = STEP_NONE;
    stepEn   = 1'b0;
    if (filtVld_q && lastVld_q) begin
      stepKind = classifyStep(last_q, filt_q);
    end
    if ((stepKind == STEP_UP) || (stepKind == STEP_DOWN)) begin
      if (DECODE_MODE == DECODE_X1) begin
        stepEn = !last_q[1] && filt_q[1];
      end else if (DECODE_MODE == DECODE_X2) begin
        stepEn = last_q[1] != filt_q[1];
      end else begin
        stepEn = 1'b1;
      end
    end
    stepVal = (stepKind == STEP_UP) ? count_q + 1'b1 : count_q - 1'b1;
  end

  // A load wins over a coinciding step; the overridden step neither moves
  // dir nor can raise a compare match. A new match wins over a clear.
  always_comb begin
    count_d = count_q;
    dir_d   = dir_q;
    if (ld_en_i) begin
      count_d = ld_value_i;
    end else if (stepEn) begin
      count_d = stepVal;
      dir_d   = (stepKind == STEP_UP);
    end
    pend_d = (pend_q && !clr_i) || (stepEn && !ld_en_i && (stepVal == cmp_q));
    err_d  = (err_q && !clr_i) || (stepKind == STEP_ILLEGAL);
    cmp_d  = cmp_en_i ? cmp_value_i : cmp_q;
  end

  // All channel state; compare register resets to all-ones
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      syncVld_q <= '0;
      cand_q    <= '0;
      run_q     <= '0;
      filt_q    <= '0;
      filtVld_q <= 1'b0;
      last_q    <= '0;
      lastVld_q <= 1'b0;
      count_q   <= '0;
      cmp_q     <= '1;
      dir_q     <= 1'b0;
      err_q     <= 1'b0;
      pend_q    <= 1'b0;
    end else begin
      sync1_q   <= {quad_a_i, quad_b_i};
      sync2_q   <= sync1_q;
      syncVld_q <= {syncVld_q[0], 1'b1};
      cand_q    <= cand_d;
      run_q     <= run_d;
      filt_q    <= filt_d;
      filtVld_q <= filtVld_d;
      last_q    <= filt_q;
      lastVld_q <= filtVld_q;
      count_q   <= count_d;
      cmp_q     <= cmp_d;
      dir_q     <= dir_d;
      err_q     <= err_d;
      pend_q    <= pend_d;
    end
  end

  assign count_o = count_q;
  assign dir_o   = dir_q;
  assign err_o   = err_q;
  assign pend_o  = pend_q;

endmodule

// File: rtl/quad_decoder_multi.sv
// ---------------------------------------------------------------------------
// quad_decoder_multi
//   N-channel quadrature decoder between the slot pins and the SPI command
//   decoder. Holds only the ld/cmp channel demux, count packing and the
//   registered interrupt OR; all per-channel logic lives in
//   quad_decoder_multi_chan.
//   clk, resetn    : 100 MHz clock, async active-low reset
//   quad_a, quad_b : raw asynchronous A/B pins, one per channel
//   bus            : host bus (ld/cmp/clr in, counts and flags out)
// ---------------------------------------------------------------------------
module quad_decoder_multi
  import quad_decoder_multi_pkg::*;
#(
  parameter int NUM_CH      = NUM_CH_DEFAULT,
  parameter int CNT_WIDTH   = CNT_WIDTH_DEFAULT,
  parameter int FILTER_LEN  = 4,
  parameter int DECODE_MODE = DECODE_X4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [NUM_CH-1:0] quad_a,
  input  logic [NUM_CH-1:0] quad_b,
  quad_decoder_multi_if.slave bus
);

  localparam int CH_W = (NUM_CH > 1) ? clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0][CNT_WIDTH-1:0] countW;
  logic [NUM_CH-1:0]                dirW;
  logic [NUM_CH-1:0]                errW;
  logic [NUM_CH-1:0]                pendW;
  logic                             intrpt_q;

  // Channel indices >= NUM_CH never match any instance, so such loads
  // and compare writes are dropped.
  genvar n;
  generate
    for (n = 0; n < NUM_CH; n++) begin : g_chan
      quad_decoder_multi_chan #(
        .CNT_WIDTH  (CNT_WIDTH),
        .FILTER_LEN (FILTER_LEN),
        .DECODE_MODE(DECODE_MODE)
      ) u_chan (
        .clk        (clk),
        .resetn     (resetn),
        .quad_a_i   (quad_a[n]),
        .quad_b_i   (quad_b[n]),
        .ld_en_i    (bus.ld_valid && (bus.ld_ch == CH_W'(n))),
        .ld_value_i (bus.ld_value),
        .cmp_en_i   (bus.cmp_valid && (bus.cmp_ch == CH_W'(n))),
        .cmp_value_i(bus.cmp_value),
        .clr_i      (bus.intr_clr[n]),
        .count_o    (countW[n]),
        .dir_o      (dirW[n]),
        .err_o      (errW[n]),
        .pend_o     (pendW[n])
      );
    end
  endgenerate

  // Interrupt line follows the OR of pending flags one cycle later
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      intrpt_q <= 1'b0;
    end else begin
      intrpt_q <= |pendW;
    end
  end

  assign bus.count_flat = countW;
  assign bus.dir        = dirW;
  assign bus.err        = errW;
  assign bus.intr_pend  = pendW;
  assign bus.intrpt_out = intrpt_q;

endmodule

// File: tb/tb_quad_decoder_multi.sv
// ---------------------------------------------------------------------------
// tb_quad_decoder_multi
//   Directed stimulus on channel 0 of quad_decoder_multi. Each stimulus
//   task pushes the expected channel-0 snapshot (and the cycle it must
//   appear in) into a queue; a monitor pops one entry every time the
//   observed snapshot changes.
// ---------------------------------------------------------------------------
module tb_quad_decoder_multi;
  import quad_decoder_multi_pkg::*;

  localparam int NCH   = 7;
  localparam int CW    = 32;
  localparam int CHW   = 3;
  localparam int FL    = 4;
  localparam int LAT   = FL + 3;
  localparam int PHASE = 10;

  typedef struct packed {
    logic [CW-1:0] cnt;
    logic          dir;
    logic          err;
    logic          pend;
    logic          intr;
  } snap_t;

  typedef struct {
    snap_t s;
    int    cyc;
  } exp_t;

  logic           clk = 1'b0;
  logic           resetn = 1'b1;
  logic [NCH-1:0] quad_a = '0;
  logic [NCH-1:0] quad_b = '0;
  int             cyc = 0;

  exp_t           expQ[$];
  snap_t          model;
  logic [CW-1:0]  cmpVal;
  logic [1:0]     ab;
  logic [CW-1:0]  expOther [NCH];
  int             compared = 0;
  int             mismatched = 0;

  quad_decoder_multi_if #(.NUM_CH(NCH), .CNT_WIDTH(CW)) bus ();

  quad_decoder_multi #(
    .NUM_CH     (NCH),
    .CNT_WIDTH  (CW),
    .FILTER_LEN (FL),
    .DECODE_MODE(4)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .quad_a(quad_a),
    .quad_b(quad_b),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Cycle index used to time-stamp expected changes
  always @(posedge clk) cyc <= cyc + 1;

  function automatic snap_t sampleCh0();
    snap_t s;
    s.cnt  = bus.count_flat[CW-1:0];
    s.dir  = bus.dir[0];
    s.err  = bus.err[0];
    s.pend = bus.intr_pend[0];
    s.intr = bus.intrpt_out;
    return s;
  endfunction

  function automatic logic [1:0] nextAb(input logic [1:0] cur, input bit up);
    logic [1:0] nxt;
    case (cur)
      2'b00:   nxt = up ? 2'b10 : 2'b01;
      2'b10:   nxt = up ? 2'b11 : 2'b00;
      2'b11:   nxt = up ? 2'b01 : 2'b10;
      default: nxt = up ? 2'b00 : 2'b11;
    endcase
    return nxt;
  endfunction

  task automatic checkOutput(input snap_t act, input int actCyc);
    exp_t e;
    compared++;
    if (expQ.size() == 0) begin
      mismatched++;
      $display("[TB] FAIL unexpected_change: got cnt=%h dir=%b err=%b pend=%b intr=%b at cyc %0d, required no change",
               act.cnt, act.dir, act.err, act.pend, act.intr, actCyc);
    end else begin
      e = expQ.pop_front();
      if ((act !== e.s) || ((e.cyc >= 0) && (actCyc != e.cyc))) begin
        mismatched++;
        $display("[TB] FAIL ch0_snapshot: got cnt=%h dir=%b err=%b pend=%b intr=%b cyc=%0d, required cnt=%h dir=%b err=%b pend=%b intr=%b cyc=%0d",
                 act.cnt, act.dir, act.err, act.pend, act.intr, actCyc,
                 e.s.cnt, e.s.dir, e.s.err, e.s.pend, e.s.intr, e.cyc);
      end
    end
  endtask

  task automatic checkDirect(input string name, input logic [CW-1:0] act,
                             input logic [CW-1:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Monitor: every change of the channel-0 snapshot consumes one entry
  initial begin : monitor
    snap_t prev;
    snap_t cur;
    prev = '0;
    forever begin
      @(negedge clk);
      cur = sampleCh0();
      if (cur !== prev) begin
        checkOutput(cur, cyc);
        prev = cur;
      end
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pushExp(input int c);
    exp_t e;
    e.s   = model;
    e.cyc = c;
    expQ.push_back(e);
  endtask

  task automatic driveAb(input logic [1:0] v);
    quad_a[0] = v[1];
    quad_b[0] = v[0];
  endtask

  // One quadrature step on ch0; clrWith pulses intr_clr[0] on the very
  // edge that registers the step.
  task automatic applyStimulus(input bit up, input bit clrWith);
    int c;
    c = cyc;
    ab = nextAb(ab, up);
    model.cnt  = up ? model.cnt + 1 : model.cnt - 1;
    model.dir  = up;
    model.pend = (model.pend && !clrWith) || (model.cnt == cmpVal);
    model.err  = model.err && !clrWith;
    pushExp(c + LAT);
    if (model.intr != model.pend) begin
      model.intr = model.pend;
      pushExp(c + LAT + 1);
    end
    driveAb(ab);
    if (clrWith) begin
      waitCycles(LAT - 1);
      bus.intr_clr = NCH'(1);
      waitCycles(1);
      bus.intr_clr = '0;
      waitCycles(PHASE - LAT);
    end else begin
      waitCycles(PHASE);
    end
  endtask

  task automatic applyIllegal(input logic [1:0] nab);
    int c;
    c = cyc;
    ab = nab;
    model.err = 1'b1;
    pushExp(c + LAT);
    driveAb(ab);
    waitCycles(PHASE);
  endtask

  task automatic clearCh0();
    int c;
    snap_t old;
    c = cyc;
    old = model;
    model.pend = 1'b0;
    model.err  = 1'b0;
    if (model != old) pushExp(c + 1);
    if (model.intr) begin
      model.intr = 1'b0;
      pushExp(c + 2);
    end
    bus.intr_clr = NCH'(1);
    waitCycles(1);
    bus.intr_clr = '0;
    waitCycles(3);
  endtask

  task automatic loadCount(input int ch, input logic [CW-1:0] val);
    int c;
    c = cyc;
    if (ch == 0) begin
      if (model.cnt != val) begin
        model.cnt = val;
        pushExp(c + 1);
      end
    end else if (ch < NCH) begin
      expOther[ch] = val;
    end
    bus.ld_valid = 1'b1;
    bus.ld_ch    = CHW'(ch);
    bus.ld_value = val;
    waitCycles(1);
    bus.ld_valid = 1'b0;
    waitCycles(2);
  endtask

  task automatic writeCmp(input int ch, input logic [CW-1:0] val);
    if (ch == 0) cmpVal = val;
    bus.cmp_valid = 1'b1;
    bus.cmp_ch    = CHW'(ch);
    bus.cmp_value = val;
    waitCycles(1);
    bus.cmp_valid = 1'b0;
    waitCycles(2);
  endtask

  // Step and load land on the same edge; the load value must win
  task automatic applyLoadStep(input bit up, input logic [CW-1:0] val);
    int c;
    c = cyc;
    ab = nextAb(ab, up);
    model.cnt = val;
    pushExp(c + LAT);
    driveAb(ab);
    waitCycles(LAT - 1);
    bus.ld_valid = 1'b1;
    bus.ld_ch    = '0;
    bus.ld_value = val;
    waitCycles(1);
    bus.ld_valid = 1'b0;
    waitCycles(PHASE - LAT);
  endtask

  task automatic checkAllZero(input string tag);
    for (int ch = 0; ch < NCH; ch++) begin
      checkDirect($sformatf("%s_count%0d", tag, ch), bus.count_flat[ch*CW +: CW], '0);
    end
    checkDirect({tag, "_dir"},  CW'(bus.dir), '0);
    checkDirect({tag, "_err"},  CW'(bus.err), '0);
    checkDirect({tag, "_pend"}, CW'(bus.intr_pend), '0);
    checkDirect({tag, "_intr"}, CW'(bus.intrpt_out), '0);
  endtask

  initial begin
    bus.ld_valid  = 1'b0;
    bus.ld_ch     = '0;
    bus.ld_value  = '0;
    bus.cmp_valid = 1'b0;
    bus.cmp_ch    = '0;
    bus.cmp_value = '0;
    bus.intr_clr  = '0;
    model  = '0;
    cmpVal = '1;
    ab     = 2'b00;
    for (int i = 0; i < NCH; i++) expOther[i] = '0;

    #2 resetn = 1'b0;
    waitCycles(3);
    checkAllZero("reset");
    resetn = 1'b1;
    waitCycles(20);

    // x4: 200 forward cycles then 100 reverse
    $display("[TB] x4 forward/reverse");
    for (int i = 0; i < 800; i++) applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 400; i++) applyStimulus(1'b0, 1'b0);

    // Glitch: 2-clk pulse rejected, 6-clk pulse accepted (+1 then -1)
    $display("[TB] glitch filter");
    quad_a[0] = 1'b1;
    waitCycles(2);
    quad_a[0] = 1'b0;
    waitCycles(PHASE + 5);
    begin
      int c;
      c = cyc;
      ab = 2'b10;
      model.cnt = model.cnt + 1;
      model.dir = 1'b1;
      pushExp(c + LAT);
      driveAb(ab);
      waitCycles(6);
      c = cyc;
      ab = 2'b00;
      model.cnt = model.cnt - 1;
      model.dir = 1'b0;
      pushExp(c + LAT);
      driveAb(ab);
      waitCycles(PHASE);
    end

    // Illegal 00->11 then clear
    $display("[TB] illegal transition");
    applyIllegal(2'b11);
    clearCh0();

    // Wrap and load
    $display("[TB] wrap and load");
    loadCount(0, 32'hFFFF_FFFF);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyLoadStep(1'b0, 32'h1234_5678);
    clearCh0();

    // Compare match, clear colliding with a new match
    $display("[TB] compare");
    loadCount(0, 32'h0);
    writeCmp(0, 32'd5);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1);
    writeCmp(0, 32'd5);
    writeCmp(1, 32'd6);
    writeCmp(7, 32'd6);
    clearCh0();
    applyStimulus(1'b1, 1'b0);

    // Other channels: load demux and out-of-range index
    loadCount(3, 32'hA5A5_0003);
    loadCount(7, 32'hDEAD_BEEF);
    for (int ch = 1; ch < NCH; ch++) begin
      checkDirect($sformatf("count_ch%0d", ch), bus.count_flat[ch*CW +: CW], expOther[ch]);
    end
    checkDirect("others_err",  CW'(bus.err[NCH-1:1]), '0);
    checkDirect("others_pend", CW'(bus.intr_pend[NCH-1:1]), '0);

    // Reset mid-operation with pins parked at 11
    $display("[TB] reset mid-operation");
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    model  = '0;
    cmpVal = '1;
    pushExp(-1);
    resetn = 1'b0;
    waitCycles(2);
    checkAllZero("midreset");
    waitCycles(3);
    resetn = 1'b1;
    waitCycles(30);
    applyStimulus(1'b1, 1'b0);
    waitCycles(PHASE);

    compared++;
    if (expQ.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL missing_changes: got %0d expected changes never seen, required 0", expQ.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
